// File: rtl/line_follow_pkg.sv
// ---------------------------------------------------------------------------
// line_follow_pkg
// Shared constants for the line-following controller:
//   DIR_W          width of the H-bridge direction word
//   DIR_*          H-bridge direction encodings
//   OUT_*          outer (mission) state encodings
//   IN_*           inner (steering) state encodings
// ---------------------------------------------------------------------------
package line_follow_pkg;

  localparam int DIR_W = 4;

  localparam logic [DIR_W-1:0] DIR_STOP  = 4'b0000;
  localparam logic [DIR_W-1:0] DIR_FWD   = 4'b0110;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0101;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b1010;
  localparam logic [DIR_W-1:0] DIR_BWD   = 4'b1001;

  localparam logic [1:0] OUT_ARMED = 2'd0;
  localparam logic [1:0] OUT_REARM = 2'd1;
  localparam logic [1:0] OUT_TASK  = 2'd2;
  localparam logic [1:0] OUT_HALT  = 2'd3;

  localparam logic [2:0] IN_FWD   = 3'd0;
  localparam logic [2:0] IN_LEFT  = 3'd1;
  localparam logic [2:0] IN_RIGHT = 3'd2;
  localparam logic [2:0] IN_BWD   = 3'd3;
  localparam logic [2:0] IN_STOP  = 3'd4;

endpackage

// File: rtl/line_follow_ctrl_ir_debounce.sv
// ---------------------------------------------------------------------------
// ir_debounce
// Accepts a new IR level only after IR_DEB consecutive raw samples that
// differ from the current debounced level.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; level and counter cleared
//   ir_i     raw IR beacon sample
//   level_o  debounced level (registered)
//   rise_o   high during the cycle whose clock edge accepts a 0->1 change
// ---------------------------------------------------------------------------
module ir_debounce #(
  parameter int IR_DEB = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ir_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (IR_DEB < 2) ? 1 : $clog2(IR_DEB);

  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          accept;

  // The current sample is the IR_DEB-th consecutive differing one.
  assign accept = (ir_i != level_q) && (cnt_q == CW'(IR_DEB - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (ir_i == level_q) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      level_q <= ir_i;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign level_o = level_q;
  // Strobe aligned with the accepting edge so the consumer acts on that edge.
  assign rise_o  = accept & ir_i;

endmodule

// File: rtl/line_follow_ctrl.sv
// ---------------------------------------------------------------------------
// line_follow_ctrl
// Line-following motion controller: IPS sensor array -> H-bridge direction
// and motor duties, with a debounced IR hand-off to a servo task module and
// a lost-line timeout that latches a fault.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   ips          NUM_IPS sensor bits, 1 = line under sensor (MSB leftmost)
//   ir           raw IR beacon detect
//   task_done    servo task finished (level or pulse)
//   direction    H-bridge direction word
//   duty_a/b     motor duties (both motors always share one duty)
//   task_enable  servo task run request
//   task_reset   one-cycle servo task clear on task completion
//   lost_fault   sticky lost-line fault
// ---------------------------------------------------------------------------
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int NUM_IPS     = 5,
  parameter int DUTY_W      = 12,
  parameter int DUTY_FWD    = 4000,
  parameter int DUTY_HARD   = 3000,
  parameter int DUTY_SOFT   = 2000,
  parameter int IR_DEB      = 4,
  parameter int LOST_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IPS-1:0] ips,
  input  logic               ir,
  input  logic               task_done,
  output logic [DIR_W-1:0]   direction,
  output logic [DUTY_W-1:0]  duty_a,
  output logic [DUTY_W-1:0]  duty_b,
  output logic               task_enable,
  output logic               task_reset,
  output logic               lost_fault
);

  localparam int C   = (NUM_IPS - 1) / 2;
  localparam int LCW = $clog2(LOST_CYCLES + 1);

  localparam logic [DUTY_W-1:0] D_FWD  = DUTY_W'(DUTY_FWD);
  localparam logic [DUTY_W-1:0] D_HARD = DUTY_W'(DUTY_HARD);
  localparam logic [DUTY_W-1:0] D_SOFT = DUTY_W'(DUTY_SOFT);
  localparam logic [LCW-1:0]    L_MAX  = LCW'(LOST_CYCLES);

  // ---------------- IR debounce ----------------
  logic ir_level;
  logic ir_rise;

  ir_debounce #(.IR_DEB(IR_DEB)) u_ir_debounce (
    .clk     (clk),
    .reset   (reset),
    .ir_i    (ir),
    .level_o (ir_level),
    .rise_o  (ir_rise)
  );

  // ---------------- sensor decode ----------------
  logic [NUM_IPS-1:0] left_mask;
  logic [NUM_IPS-1:0] right_mask;
  logic [NUM_IPS-1:0] centre_mask;

  for (genvar gi = 0; gi < NUM_IPS; gi++) begin : g_mask
    assign left_mask[gi]   = (gi > C);
    assign right_mask[gi]  = (gi < C);
    assign centre_mask[gi] = (gi == C);
  end

  logic any_left, any_right, all_ones, only_centre, none;

  assign any_left    = |(ips & left_mask);
  assign any_right   = |(ips & right_mask);
  assign all_ones    = &ips;
  assign only_centre = (ips == centre_mask);
  assign none        = ~|ips;

  // ---------------- state ----------------
  logic [1:0]        outer_q,  outer_d;
  logic [2:0]        inner_q,  inner_d;
  logic [DIR_W-1:0]  dir_q,    dir_d;
  logic [DUTY_W-1:0] duty_q,   duty_d;
  logic              task_en_q, task_en_d;
  logic              task_rst_q, task_rst_d;
  logic              fault_q,  fault_d;
  logic [LCW-1:0]    lost_q,   lost_d;
  logic              lost_sat;

  assign lost_sat = (lost_q == L_MAX);

  always_comb begin
    outer_d    = outer_q;
    inner_d    = inner_q;
    dir_d      = dir_q;
    duty_d     = duty_q;
    task_en_d  = task_en_q;
    task_rst_d = 1'b0;
    fault_d    = fault_q;
    lost_d     = lost_q;

    case (outer_q)
      OUT_ARMED, OUT_REARM: begin
        if (none) begin
          lost_d = lost_sat ? lost_q : lost_q + LCW'(1);
        end else begin
          lost_d = '0;
        end

        // STOP is sticky: steering is frozen until TASK entry or reset.
        if (inner_q != IN_STOP) begin
          if (all_ones) begin
            inner_d = IN_STOP;
            dir_d   = DIR_STOP;
            duty_d  = '0;
          end else if (only_centre) begin
            inner_d = IN_FWD;
            dir_d   = DIR_FWD;
            duty_d  = D_FWD;
          end else if (any_left && !any_right) begin
            inner_d = IN_LEFT;
            dir_d   = DIR_LEFT;
            duty_d  = ips[NUM_IPS-1] ? D_HARD : D_SOFT;
          end else if (any_right && !any_left) begin
            inner_d = IN_RIGHT;
            dir_d   = DIR_RIGHT;
            duty_d  = ips[0] ? D_HARD : D_SOFT;
          end else if (none) begin
            // Line lost: keep pivoting the way we were turning, otherwise back up.
            if (inner_q == IN_LEFT) begin
              dir_d  = DIR_LEFT;
              duty_d = D_HARD;
            end else if (inner_q == IN_RIGHT) begin
              dir_d  = DIR_RIGHT;
              duty_d = D_HARD;
            end else begin
              inner_d = IN_BWD;
              dir_d   = DIR_BWD;
              duty_d  = D_FWD;
            end
          end
          // Line on both sides (not all): hold everything.
        end

        // IR hand-off outranks the lost-line timeout on the same edge.
        // In REARM a rise is only honoured once the debounced level has dropped.
        if (ir_rise && (outer_q == OUT_ARMED || !ir_level)) begin
          outer_d   = OUT_TASK;
          inner_d   = IN_FWD;
          dir_d     = DIR_STOP;
          duty_d    = '0;
          task_en_d = 1'b0;
          lost_d    = '0;
        end else if (lost_sat) begin
          outer_d = OUT_HALT;
          dir_d   = DIR_STOP;
          duty_d  = '0;
          fault_d = 1'b1;
        end else if (outer_q == OUT_REARM && !ir_level) begin
          outer_d = OUT_ARMED;
        end
      end

      OUT_TASK: begin
        // task_done is only meaningful once the enable has been presented.
        if (task_en_q && task_done) begin
          outer_d    = OUT_REARM;
          task_en_d  = 1'b0;
          task_rst_d = 1'b1;
          lost_d     = '0;
        end else begin
          task_en_d = 1'b1;
        end
      end

      default: begin
        // HALT: terminal until reset.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outer_q    <= OUT_ARMED;
      inner_q    <= IN_FWD;
      dir_q      <= DIR_STOP;
      duty_q     <= '0;
      task_en_q  <= 1'b0;
      task_rst_q <= 1'b0;
      fault_q    <= 1'b0;
      lost_q     <= '0;
    end else begin
      outer_q    <= outer_d;
      inner_q    <= inner_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
      task_en_q  <= task_en_d;
      task_rst_q <= task_rst_d;
      fault_q    <= fault_d;
      lost_q     <= lost_d;
    end
  end

  assign direction   = dir_q;
  assign duty_a      = duty_q;
  assign duty_b      = duty_q;
  assign task_enable = task_en_q;
  assign task_reset  = task_rst_q;
  assign lost_fault  = fault_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_follow_ctrl
// Directed table, hand-written corner sequences and randomized stimulus for
// line_follow_ctrl, each step compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_line_follow_ctrl;

  localparam int N    = 5;
  localparam int C    = 2;
  localparam int IRD  = 4;
  localparam int LOST = 20;
  localparam int DF   = 4000;
  localparam int DH   = 3000;
  localparam int DS   = 2000;

  localparam logic [3:0] D_STOP = 4'b0000;
  localparam logic [3:0] D_FWD  = 4'b0110;
  localparam logic [3:0] D_LEFT = 4'b0101;
  localparam logic [3:0] D_RGT  = 4'b1010;
  localparam logic [3:0] D_BWD  = 4'b1001;
  localparam logic [4:0] CEN    = 5'b00100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ips = '0;
  logic        ir = 1'b0;
  logic        task_done = 1'b0;
  logic [3:0]  direction;
  logic [11:0] duty_a, duty_b;
  logic        task_enable, task_reset, lost_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  line_follow_ctrl #(
    .NUM_IPS(N), .DUTY_W(12), .DUTY_FWD(DF), .DUTY_HARD(DH), .DUTY_SOFT(DS),
    .IR_DEB(IRD), .LOST_CYCLES(LOST)
  ) dut (
    .clk(clk), .reset(reset), .ips(ips), .ir(ir), .task_done(task_done),
    .direction(direction), .duty_a(duty_a), .duty_b(duty_b),
    .task_enable(task_enable), .task_reset(task_reset), .lost_fault(lost_fault)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 armed, 1 rearm, 2 task, 3 halt
  // head: 0 fwd, 1 left, 2 right, 3 back, 4 stopped
  int         m_mode, m_head, m_duty, m_lost;
  logic [3:0] m_dir;
  bit         m_en, m_trst, m_fault, m_lvl;
  bit         m_hist[$];

  task automatic m_step(input logic [4:0] p, input bit irv, input bit done, input bit rst);
    bit old_lvl, rise, all_diff;
    int nl, nr, prev_lost;
    if (rst) begin
      m_mode = 0; m_head = 0; m_dir = D_STOP; m_duty = 0; m_lost = 0;
      m_en = 0; m_trst = 0; m_fault = 0; m_lvl = 0; m_hist.delete();
      return;
    end
    old_lvl = m_lvl;
    rise = 0;
    m_hist.push_back(irv);
    if (m_hist.size() > IRD) void'(m_hist.pop_front());
    if (m_hist.size() == IRD) begin
      all_diff = 1;
      foreach (m_hist[k]) if (m_hist[k] == m_lvl) all_diff = 0;
      if (all_diff) begin
        m_lvl = !m_lvl;
        rise = m_lvl;
        m_hist.delete();
      end
    end
    m_trst = 0;
    prev_lost = m_lost;
    case (m_mode)
      2: begin
        if (m_en && done) begin
          m_en = 0; m_trst = 1; m_mode = 1; m_lost = 0;
        end else begin
          m_en = 1;
        end
      end
      3: ;
      default: begin
        nl = 0; nr = 0;
        for (int i = 0; i < N; i++) begin
          if (p[i] && i > C) nl++;
          if (p[i] && i < C) nr++;
        end
        m_lost = (p == 0) ? ((m_lost < LOST) ? m_lost + 1 : LOST) : 0;
        if (m_head != 4) begin
          if (p == 5'b11111) begin
            m_head = 4; m_dir = D_STOP; m_duty = 0;
          end else if (p == CEN) begin
            m_head = 0; m_dir = D_FWD; m_duty = DF;
          end else if (nl > 0 && nr == 0) begin
            m_head = 1; m_dir = D_LEFT; m_duty = p[N-1] ? DH : DS;
          end else if (nr > 0 && nl == 0) begin
            m_head = 2; m_dir = D_RGT; m_duty = p[0] ? DH : DS;
          end else if (p == 0) begin
            if (m_head == 1 || m_head == 2) m_duty = DH;
            else begin m_head = 3; m_dir = D_BWD; m_duty = DF; end
          end
        end
        if (rise && (m_mode == 0 || !old_lvl)) begin
          m_mode = 2; m_head = 0; m_dir = D_STOP; m_duty = 0; m_en = 0; m_lost = 0;
        end else if (prev_lost == LOST) begin
          m_mode = 3; m_dir = D_STOP; m_duty = 0; m_fault = 1;
        end else if (m_mode == 1 && !old_lvl) begin
          m_mode = 0;
        end
      end
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, step_no, act, exp);
    end
  endtask

  task automatic do_step(input logic [4:0] p, input bit irv, input bit done, input bit rst);
    ips = p; ir = irv; task_done = done; reset = rst;
    @(posedge clk);
    m_step(p, irv, done, rst);
    #1;
    step_no++;
    check("model_dir",   32'(direction),   32'(m_dir));
    check("model_dutya", 32'(duty_a),      32'(m_duty));
    check("model_dutyb", 32'(duty_b),      32'(m_duty));
    check("model_en",    32'(task_enable), 32'(m_en));
    check("model_trst",  32'(task_reset),  32'(m_trst));
    check("model_fault", 32'(lost_fault),  32'(m_fault));
    $display("[TB] step %0d ips=%b ir=%0d done=%0d rst=%0d -> dir=%b duty=%0d/%0d en=%0d trst=%0d fault=%0d",
             step_no, p, irv, done, rst, direction, duty_a, duty_b, task_enable, task_reset, lost_fault);
  endtask

  task automatic expect_out(input string nm, input logic [3:0] d, input int du,
                            input bit en, input bit tr, input bit f);
    check({nm, "_dir"},   32'(direction),   32'(d));
    check({nm, "_duty"},  32'(duty_a),      32'(du));
    check({nm, "_en"},    32'(task_enable), 32'(en));
    check({nm, "_trst"},  32'(task_reset),  32'(tr));
    check({nm, "_fault"}, 32'(lost_fault),  32'(f));
  endtask

  typedef struct {
    logic [4:0] p;
    bit         irv;
    bit         done;
    bit         rst;
    logic [3:0] dir;
    int         duty;
    bit         en;
    bit         trst;
    bit         fault;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [4:0] cur;
    bit         irv;
    int         run_left;

    // ---------- table: steering, lost pivot, hold, sticky STOP ----------
    tbl.push_back('{5'b00100, 0, 0, 1, D_STOP, 0,  0, 0, 0});
    tbl.push_back('{5'b00100, 0, 0, 0, D_FWD,  DF, 0, 0, 0});
    tbl.push_back('{5'b11000, 0, 0, 0, D_LEFT, DH, 0, 0, 0});
    tbl.push_back('{5'b01000, 0, 0, 0, D_LEFT, DS, 0, 0, 0});
    tbl.push_back('{5'b00000, 0, 0, 0, D_LEFT, DH, 0, 0, 0});
    tbl.push_back('{5'b00110, 0, 0, 0, D_RGT,  DS, 0, 0, 0});
    tbl.push_back('{5'b00001, 0, 0, 0, D_RGT,  DH, 0, 0, 0});
    tbl.push_back('{5'b10001, 0, 0, 0, D_RGT,  DH, 0, 0, 0});
    tbl.push_back('{5'b00100, 0, 0, 0, D_FWD,  DF, 0, 0, 0});
    tbl.push_back('{5'b00000, 0, 0, 0, D_BWD,  DF, 0, 0, 0});
    tbl.push_back('{5'b11111, 0, 0, 0, D_STOP, 0,  0, 0, 0});
    tbl.push_back('{5'b00100, 0, 0, 0, D_STOP, 0,  0, 0, 0});
    tbl.push_back('{5'b10000, 0, 0, 0, D_STOP, 0,  0, 0, 0});
    tbl.push_back('{5'b00100, 0, 0, 1, D_STOP, 0,  0, 0, 0});
    tbl.push_back('{5'b00100, 0, 0, 0, D_FWD,  DF, 0, 0, 0});
    foreach (tbl[i]) begin
      do_step(tbl[i].p, tbl[i].irv, tbl[i].done, tbl[i].rst);
      expect_out("table", tbl[i].dir, tbl[i].duty, tbl[i].en, tbl[i].trst, tbl[i].fault);
    end

    // ---------- lost-line timeout, counter clear, halt, reset ----------
    do_step(CEN, 0, 0, 1);
    do_step(CEN, 0, 0, 0);
    for (int i = 0; i < LOST - 1; i++) do_step(5'b0, 0, 0, 0);
    expect_out("lost_bwd", D_BWD, DF, 0, 0, 0);
    do_step(CEN, 0, 0, 0);
    expect_out("lost_clear", D_FWD, DF, 0, 0, 0);
    for (int i = 0; i < LOST; i++) do_step(5'b0, 0, 0, 0);
    expect_out("lost_sat", D_BWD, DF, 0, 0, 0);
    do_step(5'b0, 0, 0, 0);
    expect_out("halt", D_STOP, 0, 0, 0, 1);
    do_step(CEN, 0, 0, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("halt_hold", D_STOP, 0, 0, 0, 1);
    do_step(CEN, 0, 0, 1);
    expect_out("halt_reset", D_STOP, 0, 0, 0, 0);

    // ---------- IR debounce, task hand-off, rearm ----------
    do_step(CEN, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_step(CEN, 1, 0, 0);
    expect_out("ir3_no_task", D_FWD, DF, 0, 0, 0);
    do_step(CEN, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_step(CEN, 1, 0, 0);
    do_step(CEN, 1, 1, 0);
    expect_out("task_entry", D_STOP, 0, 0, 0, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("task_en", D_STOP, 0, 1, 0, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("task_wait", D_STOP, 0, 1, 0, 0);
    do_step(CEN, 1, 1, 0);
    expect_out("task_done", D_STOP, 0, 0, 1, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("rearm_follow", D_FWD, DF, 0, 0, 0);
    for (int i = 0; i < 5; i++) do_step(CEN, 1, 0, 0);
    expect_out("rearm_ir_high", D_FWD, DF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_step(CEN, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_step(CEN, 1, 0, 0);
    expect_out("rearm_pre", D_FWD, DF, 0, 0, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("task_again", D_STOP, 0, 0, 0, 0);
    do_step(CEN, 1, 0, 0);
    expect_out("task_again_en", D_STOP, 0, 1, 0, 0);
    do_step(CEN, 1, 1, 1);
    expect_out("task_reset_mid", D_STOP, 0, 0, 0, 0);

    // ---------- IR accept on the timeout edge: TASK wins ----------
    do_step(CEN, 0, 0, 0);
    for (int i = 0; i < LOST; i++) do_step(5'b0, (i >= LOST - 3), 0, 0);
    do_step(5'b0, 1, 0, 0);
    expect_out("ir_vs_timeout", D_STOP, 0, 0, 0, 0);
    do_step(5'b0, 1, 0, 0);
    expect_out("ir_vs_timeout_en", D_STOP, 0, 1, 0, 0);
    do_step(5'b0, 1, 1, 0);
    do_step(5'b0, 1, 0, 0);
    expect_out("after_task_lost", D_BWD, DF, 0, 0, 0);

    // ---------- randomized ----------
    do_step(CEN, 0, 0, 1);
    cur = CEN;
    irv = 0;
    run_left = 0;
    for (int it = 0; it < 900; it++) begin
      if (run_left == 0) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) begin
          cur = 5'b0;
          run_left = $urandom_range(5, 25);
        end else if (r < 17) begin
          cur = 5'b11111;
          run_left = 1;
        end else begin
          cur = 5'($urandom_range(1, 30));
          run_left = $urandom_range(1, 4);
        end
      end
      if ($urandom_range(0, 5) == 0) irv = !irv;
      do_step(cur, irv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));
      run_left--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
